pc_select_ctrl: RTL and testbench

Parametrised next-PC controller for the core's fetch stage. It replaces the fixed 2-bit PC-source decode with a registered program counter and a priority select over sequential, branch, jump, jump-register and exception sources. It queues a redirect that arrives during a stall and applies it when the stall clears. After every redirect it drives a timed pipeline flush.

---
 rtl/pc_select_pkg.sv | 14 +
 rtl/pc_redirect_arb.sv | 49 ++++
 rtl/pc_select_ctrl.sv | 125 ++++++++++++
 tb/tb_pc_select_ctrl.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/pc_select_pkg.sv
// Shared types and constants for the fetch-stage next-PC controller.
package pc_select_pkg;

  typedef enum logic [2:0] {
    PCSRC_SEQ = 3'b000,
    PCSRC_BR  = 3'b001,
    PCSRC_J   = 3'b010,
    PCSRC_JR  = 3'b011,
    PCSRC_EXC = 3'b100
  } pcsrc_e;

  localparam logic [31:0] DEFAULT_EXC_VECTOR = 32'h0000_0080;

endpackage

// File: rtl/pc_redirect_arb.sv
// Combinational priority arbiter over redirect requests: exc > jr > j > taken branch.
module pc_redirect_arb
  import pc_select_pkg::*;
#(
  parameter int unsigned WIDTH      = 32,
  parameter logic [31:0] EXC_VECTOR = DEFAULT_EXC_VECTOR
) (
  input  logic             branch_i,
  input  logic             branch_taken_i,
  input  logic [WIDTH-1:0] branch_target_i,
  input  logic             j_i,
  input  logic [WIDTH-1:0] j_target_i,
  input  logic             jr_i,
  input  logic [WIDTH-1:0] jr_target_i,
  input  logic             exc_i,
  output logic             valid_o,
  output pcsrc_e           src_o,
  output logic [WIDTH-1:0] target_o,
  output logic             misalign_o
);

  logic [WIDTH-1:0] raw;

  always_comb begin
    valid_o = 1'b1;
    src_o   = PCSRC_SEQ;
    raw     = '0;
    if (exc_i) begin
      src_o = PCSRC_EXC;
      raw   = EXC_VECTOR[WIDTH-1:0];
    end else if (jr_i) begin
      src_o = PCSRC_JR;
      raw   = jr_target_i;
    end else if (j_i) begin
      src_o = PCSRC_J;
      raw   = j_target_i;
    end else if (branch_i && branch_taken_i) begin
      src_o = PCSRC_BR;
      raw   = branch_target_i;
    end else begin
      valid_o = 1'b0;
    end
  end

  // Targets are word aligned; the flag reports dropped low bits to the caller.
  assign target_o   = {raw[WIDTH-1:2], 2'b00};
  assign misalign_o = valid_o && (src_o != PCSRC_EXC) && (raw[1:0] != 2'b00);

endmodule

// File: rtl/pc_select_ctrl.sv
// Fetch-stage next-PC controller: registered PC, stall-time redirect queue, timed flush.
module pc_select_ctrl
  import pc_select_pkg::*;
#(
  parameter int unsigned WIDTH       = 32,
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter logic [31:0] EXC_VECTOR  = DEFAULT_EXC_VECTOR,
  parameter int unsigned FLUSH_DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall_i,
  input  logic             branch_i,
  input  logic             branch_taken_i,
  input  logic [WIDTH-1:0] branch_target_i,
  input  logic             j_i,
  input  logic [WIDTH-1:0] j_target_i,
  input  logic             jr_i,
  input  logic [WIDTH-1:0] jr_target_i,
  input  logic             exc_i,
  output logic [WIDTH-1:0] pc_o,
  output logic [2:0]       pcsrc_o,
  output logic             flush_o,
  output logic             pending_o,
  output logic             align_err_o
);

  logic             arb_valid;
  pcsrc_e           arb_src;
  logic [WIDTH-1:0] arb_target;
  logic             arb_misalign;

  pc_redirect_arb #(
    .WIDTH      (WIDTH),
    .EXC_VECTOR (EXC_VECTOR)
  ) u_arb (
    .branch_i        (branch_i),
    .branch_taken_i  (branch_taken_i),
    .branch_target_i (branch_target_i),
    .j_i             (j_i),
    .j_target_i      (j_target_i),
    .jr_i            (jr_i),
    .jr_target_i     (jr_target_i),
    .exc_i           (exc_i),
    .valid_o         (arb_valid),
    .src_o           (arb_src),
    .target_o        (arb_target),
    .misalign_o      (arb_misalign)
  );

  logic [WIDTH-1:0] pc_q, pc_d;
  pcsrc_e           src_q, src_d;
  logic [2:0]       cnt_q, cnt_d;
  logic             align_q, align_d;
  logic             pend_q, pend_d;
  pcsrc_e           pend_src_q, pend_src_d;
  logic [WIDTH-1:0] pend_tgt_q, pend_tgt_d;
  logic             pend_mis_q, pend_mis_d;

  always_comb begin
    pc_d       = pc_q;
    src_d      = src_q;
    cnt_d      = cnt_q;
    align_d    = 1'b0;
    pend_d     = pend_q;
    pend_src_d = pend_src_q;
    pend_tgt_d = pend_tgt_q;
    pend_mis_d = pend_mis_q;
    if (!stall_i) begin
      pend_d = 1'b0;
      // Exceptions bypass the queue; otherwise a queued redirect beats new requests.
      if (pend_q && !exc_i) begin
        pc_d    = pend_tgt_q;
        src_d   = pend_src_q;
        align_d = pend_mis_q;
      end else if (arb_valid) begin
        pc_d    = arb_target;
        src_d   = arb_src;
        align_d = arb_misalign;
      end else begin
        pc_d  = pc_q + WIDTH'(4);
        src_d = PCSRC_SEQ;
      end
      if (src_d != PCSRC_SEQ) begin
        cnt_d = 3'(FLUSH_DEPTH);
      end else if (cnt_q != 3'd0) begin
        cnt_d = cnt_q - 3'd1;
      end
    end else if (arb_valid && (!pend_q || exc_i)) begin
      pend_d     = 1'b1;
      pend_src_d = arb_src;
      pend_tgt_d = arb_target;
      pend_mis_d = arb_misalign;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q       <= RESET_PC[WIDTH-1:0];
      src_q      <= PCSRC_SEQ;
      cnt_q      <= 3'd0;
      align_q    <= 1'b0;
      pend_q     <= 1'b0;
      pend_src_q <= PCSRC_SEQ;
      pend_tgt_q <= '0;
      pend_mis_q <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      src_q      <= src_d;
      cnt_q      <= cnt_d;
      align_q    <= align_d;
      pend_q     <= pend_d;
      pend_src_q <= pend_src_d;
      pend_tgt_q <= pend_tgt_d;
      pend_mis_q <= pend_mis_d;
    end
  end

  assign pc_o        = pc_q;
  assign pcsrc_o     = src_q;
  assign flush_o     = (cnt_q != 3'd0);
  assign pending_o   = pend_q;
  assign align_err_o = align_q;

endmodule

// File: tb/tb_pc_select_ctrl.sv
// Directed, table-driven bench for pc_select_ctrl with default parameters.
module tb_pc_select_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall_i, branch_i, branch_taken_i, j_i, jr_i, exc_i;
  logic [31:0] branch_target_i, j_target_i, jr_target_i;
  logic [31:0] pc_o;
  logic [2:0]  pcsrc_o;
  logic        flush_o, pending_o, align_err_o;

  int n_checks = 0;
  int n_errors = 0;

  pc_select_ctrl dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .stall_i         (stall_i),
    .branch_i        (branch_i),
    .branch_taken_i  (branch_taken_i),
    .branch_target_i (branch_target_i),
    .j_i             (j_i),
    .j_target_i      (j_target_i),
    .jr_i            (jr_i),
    .jr_target_i     (jr_target_i),
    .exc_i           (exc_i),
    .pc_o            (pc_o),
    .pcsrc_o         (pcsrc_o),
    .flush_o         (flush_o),
    .pending_o       (pending_o),
    .align_err_o     (align_err_o)
  );

  always #5 clk = ~clk;

  // req bits: {stall, exc, jr, j, branch, branch_taken}
  typedef struct {
    logic [5:0]  req;
    logic [31:0] bt, jt, jrt;
    logic [31:0] epc;
    logic [2:0]  esrc;
    logic        efl, epd, eal;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t v(logic [5:0] req, logic [31:0] bt, logic [31:0] jt,
                             logic [31:0] jrt, logic [31:0] epc, logic [2:0] esrc,
                             logic efl, logic epd, logic eal);
    vec_t r;
    r.req = req; r.bt = bt; r.jt = jt; r.jrt = jrt;
    r.epc = epc; r.esrc = esrc; r.efl = efl; r.epd = epd; r.eal = eal;
    return r;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic check_all(string tag, logic [31:0] epc, logic [2:0] esrc,
                           logic efl, logic epd, logic eal);
    check({tag, " pc"}, pc_o, epc);
    check({tag, " pcsrc"}, 32'(pcsrc_o), 32'(esrc));
    check({tag, " flush"}, 32'(flush_o), 32'(efl));
    check({tag, " pending"}, 32'(pending_o), 32'(epd));
    check({tag, " align_err"}, 32'(align_err_o), 32'(eal));
  endtask

  task automatic drive(logic [5:0] req, logic [31:0] bt, logic [31:0] jt, logic [31:0] jrt);
    {stall_i, exc_i, jr_i, j_i, branch_i, branch_taken_i} = req;
    branch_target_i = bt;
    j_target_i      = jt;
    jr_target_i     = jrt;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  localparam logic [5:0] IDLE = 6'b000000, STALL = 6'b100000;

  initial begin
    rst_n = 1'b0;
    drive(IDLE, '0, '0, '0);

    // Idle counting from reset
    tbl.push_back(v(IDLE, 0, 0, 0, 32'h4, 3'd0, 0, 0, 0));
    tbl.push_back(v(IDLE, 0, 0, 0, 32'h8, 3'd0, 0, 0, 0));
    tbl.push_back(v(IDLE, 0, 0, 0, 32'hC, 3'd0, 0, 0, 0));
    tbl.push_back(v(IDLE, 0, 0, 0, 32'h10, 3'd0, 0, 0, 0));
    // All requests at once: exception wins, flush lasts two cycles
    tbl.push_back(v(6'b011111, 32'h400, 32'h300, 32'h200, 32'h80, 3'd4, 1, 0, 0));
    tbl.push_back(v(IDLE, 0, 0, 0, 32'h84, 3'd0, 1, 0, 0));
    tbl.push_back(v(IDLE, 0, 0, 0, 32'h88, 3'd0, 0, 0, 0));
    // Taken without branch is ignored; taken branch; not-taken branch
    tbl.push_back(v(6'b000001, 32'h500, 0, 0, 32'h8C, 3'd0, 0, 0, 0));
    tbl.push_back(v(6'b000011, 32'h400, 0, 0, 32'h400, 3'd1, 1, 0, 0));
    tbl.push_back(v(6'b000010, 32'h600, 0, 0, 32'h404, 3'd0, 1, 0, 0));
    // j queued under stall, later jr dropped, flush count frozen
    tbl.push_back(v(6'b100100, 0, 32'h1000, 0, 32'h404, 3'd0, 1, 1, 0));
    tbl.push_back(v(6'b101000, 0, 0, 32'h2000, 32'h404, 3'd0, 1, 1, 0));
    tbl.push_back(v(STALL, 0, 0, 0, 32'h404, 3'd0, 1, 1, 0));
    tbl.push_back(v(6'b000100, 0, 32'h3000, 0, 32'h1000, 3'd2, 1, 0, 0));
    tbl.push_back(v(IDLE, 0, 0, 0, 32'h1004, 3'd0, 1, 0, 0));
    tbl.push_back(v(IDLE, 0, 0, 0, 32'h1008, 3'd0, 0, 0, 0));
    // Pending j overwritten by exception during stall
    tbl.push_back(v(6'b100100, 0, 32'h1000, 0, 32'h1008, 3'd0, 0, 1, 0));
    tbl.push_back(v(6'b110000, 0, 0, 0, 32'h1008, 3'd0, 0, 1, 0));
    tbl.push_back(v(IDLE, 0, 0, 0, 32'h80, 3'd4, 1, 0, 0));
    tbl.push_back(v(IDLE, 0, 0, 0, 32'h84, 3'd0, 1, 0, 0));
    tbl.push_back(v(IDLE, 0, 0, 0, 32'h88, 3'd0, 0, 0, 0));
    // Misaligned jr, stall mid-flush stretches flush
    tbl.push_back(v(6'b001000, 0, 0, 32'h203, 32'h200, 3'd3, 1, 0, 1));
    tbl.push_back(v(IDLE, 0, 0, 0, 32'h204, 3'd0, 1, 0, 0));
    tbl.push_back(v(STALL, 0, 0, 0, 32'h204, 3'd0, 1, 0, 0));
    tbl.push_back(v(STALL, 0, 0, 0, 32'h204, 3'd0, 1, 0, 0));
    tbl.push_back(v(IDLE, 0, 0, 0, 32'h208, 3'd0, 0, 0, 0));
    // Misaligned target through the queue flags on application
    tbl.push_back(v(6'b101000, 0, 0, 32'h3001, 32'h208, 3'd0, 0, 1, 0));
    tbl.push_back(v(IDLE, 0, 0, 0, 32'h3000, 3'd3, 1, 0, 1));
    tbl.push_back(v(IDLE, 0, 0, 0, 32'h3004, 3'd0, 1, 0, 0));
    tbl.push_back(v(IDLE, 0, 0, 0, 32'h3008, 3'd0, 0, 0, 0));
    // Unstalled exception discards the queued redirect and same-cycle j
    tbl.push_back(v(6'b100100, 0, 32'h500, 0, 32'h3008, 3'd0, 0, 1, 0));
    tbl.push_back(v(6'b010100, 0, 32'h700, 0, 32'h80, 3'd4, 1, 0, 0));
    tbl.push_back(v(IDLE, 0, 0, 0, 32'h84, 3'd0, 1, 0, 0));
    tbl.push_back(v(IDLE, 0, 0, 0, 32'h88, 3'd0, 0, 0, 0));

    #12;
    check_all("reset", 32'h0, 3'd0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    // First edge after release already advanced; re-align with the table from pc=4
    check_all("rel", 32'h4, 3'd0, 0, 0, 0);
    rst_n = 1'b0;
    #1;
    check_all("rst2", 32'h0, 3'd0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].req, tbl[i].bt, tbl[i].jt, tbl[i].jrt);
      step();
      check_all($sformatf("vec%0d", i), tbl[i].epc, tbl[i].esrc, tbl[i].efl, tbl[i].epd,
                tbl[i].eal);
    end

    // Wrap at top of address space
    drive(6'b000100, '0, 32'hFFFF_FFFC, '0);
    step();
    check_all("wrap_j", 32'hFFFF_FFFC, 3'd2, 1, 0, 0);
    drive(IDLE, '0, '0, '0);
    step();
    check_all("wrap_seq", 32'h0, 3'd0, 1, 0, 0);
    // Queue a redirect mid-flush, then reset asynchronously
    drive(6'b100100, '0, 32'h100, '0);
    step();
    check_all("pre_rst", 32'h0, 3'd0, 1, 1, 0);
    #3;
    rst_n = 1'b0;
    #1;
    check_all("async_rst", 32'h0, 3'd0, 0, 0, 0);
    drive(IDLE, '0, '0, '0);
    rst_n = 1'b1;
    step();
    check_all("post_rst", 32'h4, 3'd0, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
